// File: rtl/t9_input_writer.sv
// Debounced confirm-button writer: one press issues one single-cycle outter_input
// strobe carrying the synchronised switch bank. Optional macro SIGN_EXTEND_EN sign-extends sw.
module t9_input_writer #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] sw_data,
  input  logic                confirm_btn,
  output logic                outter_input,
  output logic [31:0]         outter_t9,
  output logic [7:0]          write_count,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, DEB_PRESS, WRITE, WAIT_REL, DEB_REL} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               load;
  logic               btn_m, btn_s;
  logic [SW_WIDTH-1:0] sw_m, sw_s;
  logic [31:0]        sw_ext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= confirm_btn;
      btn_s <= btn_m;
      sw_m  <= sw_data;
      sw_s  <= sw_m;
    end
  end

  // Zero-width replication is illegal, so the full-width case is split out.
  generate
    if (SW_WIDTH == 32) begin : g_full
      assign sw_ext = 32'(sw_s);
    end else begin : g_ext
`ifdef SIGN_EXTEND_EN
      assign sw_ext = {{(32-SW_WIDTH){sw_s[SW_WIDTH-1]}}, sw_s};
`else
      assign sw_ext = {{(32-SW_WIDTH){1'b0}}, sw_s};
`endif
    end
  endgenerate

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    case (state)
      IDLE: if (btn_s) begin
        state_n = DEB_PRESS;
        cnt_n   = CNT_W'(1);
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt >= LAST) begin
          // >= lets DEBOUNCE_CYCLES=1 exit on the first stable sample.
          state_n = WRITE;
          cnt_n   = '0;
          load    = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WRITE: state_n = WAIT_REL;
      WAIT_REL: if (!btn_s) begin
        state_n = DEB_REL;
        cnt_n   = CNT_W'(1);
      end
      DEB_REL: begin
        if (btn_s) begin
          state_n = WAIT_REL;
          cnt_n   = '0;
        end else if (cnt >= LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      outter_input <= 1'b0;
      outter_t9    <= '0;
      write_count  <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      outter_input <= load;
      if (load) begin
        outter_t9   <= sw_ext;
        write_count <= write_count + 8'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_t9_input_writer.sv
// Bench for t9_input_writer: table of presses plus hand sequences, strobes checked
// against a scoreboard queue of expected {outter_t9, write_count}.
module tb_t9_input_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw_data = '0;
  logic        confirm_btn = 1'b0;
  logic        outter_input;
  logic [31:0] outter_t9;
  logic [7:0]  write_count;
  logic        busy;

  t9_input_writer #(.SW_WIDTH(16), .DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clock(clock), .reset(reset), .sw_data(sw_data), .confirm_btn(confirm_btn),
    .outter_input(outter_input), .outter_t9(outter_t9),
    .write_count(write_count), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] t9; logic [7:0] wc; } exp_t;
  typedef struct { logic [15:0] sw; int hold; bit strobe; } vec_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_wc = '0;
  logic       prev_strobe = 1'b0;

  function automatic logic [31:0] exp_t9(input logic [15:0] sw);
`ifdef SIGN_EXTEND_EN
    return {{16{sw[15]}}, sw};
`else
    return {16'h0000, sw};
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (outter_input) begin
      check("no_back_to_back", 32'(prev_strobe), 32'd0);
      if (q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("t9", outter_t9, e.t9);
        check("wcnt", 32'(write_count), 32'(e.wc));
      end
    end
    prev_strobe = outter_input;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      mon();
    end
  endtask

  task automatic expect_strobe(input logic [15:0] sw);
    exp_wc = exp_wc + 8'd1;
    q.push_back('{exp_t9(sw), exp_wc});
  endtask

  task automatic press(input logic [15:0] sw, input int hold, input bit strobe, input bit chk);
    sw_data = sw;
    confirm_btn = 1'b1;
    if (strobe) expect_strobe(sw);
    cyc(hold);
    confirm_btn = 1'b0;
    cyc(12);
    if (chk) begin
      check("idle_after_press", 32'(busy), 32'd0);
      check("strobe_count", 32'(q.size()), 32'd0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    // A press strobes iff the raw button is high for at least DEBOUNCE_CYCLES edges.
    vecs[0] = '{16'h00A5, 20, 1'b1};
    vecs[1] = '{16'h1111, 2, 1'b0};
    vecs[2] = '{16'h2222, 3, 1'b0};
    vecs[3] = '{16'h3333, 4, 1'b1};
    vecs[4] = '{16'h8001, 6, 1'b1};
    vecs[5] = '{16'h1234, 100, 1'b1};
    vecs[6] = '{16'hFFFF, 1, 1'b0};
    vecs[7] = '{16'h7FFE, 5, 1'b1};

    @(negedge clock);
    check("rst_strobe", 32'(outter_input), 32'd0);
    check("rst_t9", outter_t9, 32'd0);
    check("rst_wcnt", 32'(write_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    cyc(2);

    // Strobe latency: high only between edges 5 and 6 counting from the first sampling edge.
    sw_data = 16'h00A5;
    confirm_btn = 1'b1;
    expect_strobe(16'h00A5);
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      check($sformatf("latency_e%0d", k), 32'(outter_input), (k == 5) ? 32'd1 : 32'd0);
    end
    cyc(12);
    check("busy_while_held", 32'(busy), 32'd1);
    check("t9_held", outter_t9, 32'h000000A5);
    confirm_btn = 1'b0;
    cyc(12);
    check("busy_released", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) press(vecs[i].sw, vecs[i].hold, vecs[i].strobe, 1'b1);

    // Three short glitches three cycles apart: no strobe, back to IDLE.
    for (int i = 0; i < 3; i++) begin
      confirm_btn = 1'b1;
      cyc(2);
      confirm_btn = 1'b0;
      cyc(3);
    end
    cyc(4);
    check("glitch_idle", 32'(busy), 32'd0);

    // Async reset at edge 3 of a debounce clears everything without a clock edge.
    sw_data = 16'h5555;
    confirm_btn = 1'b1;
    cyc(3);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_strobe", 32'(outter_input), 32'd0);
    check("arst_t9", outter_t9, 32'd0);
    check("arst_wcnt", 32'(write_count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    exp_wc = '0;
    confirm_btn = 1'b0;
    @(negedge clock);
    prev_strobe = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(10);
    check("arst_no_strobe", 32'(q.size()), 32'd0);

    // 256 presses wrap write_count back to 0.
    for (int i = 0; i < 256; i++) press(16'(i), 5, 1'b1, 1'b0);
    check("wrap_wcnt", 32'(write_count), 32'd0);
    check("wrap_drained", 32'(q.size()), 32'd0);

    // Switch change during debounce is captured; change after WRITE is ignored.
    sw_data = 16'h0001;
    confirm_btn = 1'b1;
    expect_strobe(16'h0002);
    cyc(3);
    sw_data = 16'h0002;
    cyc(5);
    sw_data = 16'h0003;
    cyc(10);
    check("late_sw_ignored", outter_t9, exp_t9(16'h0002));
    confirm_btn = 1'b0;
    cyc(12);
    check("late_sw_after_rel", outter_t9, exp_t9(16'h0002));
    check("final_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
